// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the rst_seq reset sequencer.
package rst_seq_pkg;

   typedef enum logic [1:0] {SYNC, WAIT, DONE, HOLD} rst_seq_state_e;

   // Counter must hold both the largest delay value and STRETCH-1.
   function automatic int unsigned cnt_width(input int unsigned dly_w,
                                             input int unsigned stretch);
      int unsigned s;
      s = $clog2(stretch) + 1;
      return (dly_w > s) ? dly_w : s;
   endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// Async-clear, synchronous-release reset synchroniser, STAGE flops deep.
module rst_seq_sync #(
   parameter int unsigned STAGE = 3
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic rel_o
);

   logic [STAGE-1:0] sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGE-2:0], 1'b1};
      end
   end

   assign rel_o = sync_q[STAGE-1];

endmodule

// File: rtl/rst_seq.sv
// Multi-channel ordered reset sequencer with per-channel release delays.
// Define RST_SEQ_SW_RST_EN to build the software re-reset path (HOLD state).
module rst_seq
   import rst_seq_pkg::*;
#(
   parameter int unsigned CH_NUM  = 4,
   parameter int unsigned STAGE   = 3,
   parameter int unsigned DLY_W   = 8,
   parameter int unsigned STRETCH = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [CH_NUM-1:0][DLY_W-1:0] dly_i,
   input  logic [CH_NUM-1:0]            sw_rst_req_i,
   output logic                         sw_rst_ack_o,
   output logic [CH_NUM-1:0]            rst_n_o,
   output logic                         done_o
);

   localparam int unsigned CNT_W = cnt_width(DLY_W, STRETCH);
   localparam int unsigned IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

   rst_seq_state_e    state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CH_NUM-1:0] rst_n_q, rst_n_d;
   logic              done_q, done_d;
   logic              ack_q, ack_d;
   logic              rel;
   logic [DLY_W-1:0]  dly_sel;

   rst_seq_sync #(
      .STAGE (STAGE)
   ) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .rel_o (rel)
   );

   assign dly_sel = dly_i[idx_q];

`ifdef RST_SEQ_SW_RST_EN
   logic              req_any;
   logic [IDX_W-1:0]  req_idx;
   logic [CH_NUM-1:0] req_mask;

   // Lowest requesting channel, and a mask of it plus every higher channel.
   always_comb begin
      req_idx  = '0;
      req_mask = '0;
      for (int i = CH_NUM - 1; i >= 0; i--) begin
         if (sw_rst_req_i[i]) req_idx = IDX_W'(i);
      end
      for (int i = 0; i < CH_NUM; i++) begin
         req_mask[i] = sw_rst_req_i[i] | ((i > 0) ? req_mask[(i > 0) ? i - 1 : 0] : 1'b0);
      end
   end
   assign req_any = |sw_rst_req_i;
`else
   logic unused_req;
   assign unused_req = ^sw_rst_req_i;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      rst_n_d = rst_n_q;
      done_d  = done_q;
      ack_d   = 1'b0;
      unique case (state_q)
         SYNC: begin
            if (rel) begin
               state_d = WAIT;
               idx_d   = '0;
               cnt_d   = '0;
            end
         end
         WAIT: begin
            if (cnt_q == CNT_W'(dly_sel)) begin
               rst_n_d[idx_q] = 1'b1;
               cnt_d          = '0;
               if (idx_q == IDX_W'(CH_NUM - 1)) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
`ifdef RST_SEQ_SW_RST_EN
            if (req_any) begin
               rst_n_d = rst_n_q & ~req_mask;
               done_d  = 1'b0;
               idx_d   = req_idx;
               cnt_d   = '0;
               ack_d   = 1'b1;
               state_d = HOLD;
            end
`endif
         end
`ifdef RST_SEQ_SW_RST_EN
         HOLD: begin
            // Any request restarts the stretch window; no second ack.
            if (req_any) begin
               rst_n_d = rst_n_q & ~req_mask;
               idx_d   = (req_idx < idx_q) ? req_idx : idx_q;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(STRETCH - 1)) begin
               state_d = WAIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= SYNC;
         idx_q   <= '0;
         cnt_q   <= '0;
         rst_n_q <= '0;
         done_q  <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         rst_n_q <= rst_n_d;
         done_q  <= done_d;
         ack_q   <= ack_d;
      end
   end

   assign rst_n_o      = rst_n_q;
   assign done_o       = done_q;
   assign sw_rst_ack_o = ack_q;

endmodule

// File: doc/rst_seq.md
# rst_seq

Multi-channel reset sequencer. It takes one asynchronous, active-high reset and drives CH_NUM active-low reset outputs. Assertion is asynchronous; release is synchronous and ordered, with a configurable delay per channel. An optional software-reset path re-asserts any channel together with all higher-index (dependent) channels, then re-runs the release sequence. It sits at the top of each clock domain, after the clock generator, and feeds per-subsystem resets (bus, core, peripherals).

## Interface
Parameters:
- CH_NUM, 4, number of reset output channels (≥1); channel 0 is released first.
- STAGE, 3, depth of the release synchroniser (≥2).
- DLY_W, 8, width of each per-channel delay field.
- STRETCH, 16, minimum software-reset assertion in cycles (≥1).

Ports:
- clk_i, in, 1, domain clock.
- rst_i, in, 1, asynchronous active-high reset. Fixed: one clock; reset is asynchronous and active-high.
- dly_i, in, [CH_NUM-1:0][DLY_W-1:0], per-channel release delay. Quasi-static: change it only while done_o=1.
- sw_rst_req_i, in, CH_NUM, level software-reset request per channel.
- sw_rst_ack_o, out, 1, one-cycle pulse when a software request is accepted.
- rst_n_o, out, CH_NUM, active-low channel resets.
- done_o, out, 1, high when all channels are released.

## Operation
- Reset values: rst_n_o = '0, done_o = 0, sw_rst_ack_o = 0, state SYNC, idx = 0, cnt = 0.
- rst_i assertion clears all flops asynchronously at any time, including mid-sequence or mid-HOLD.
- Synchroniser: STAGE flops, async-cleared by rst_i, shifting in 1. Its last stage is `rel`.
- FSM states: SYNC, WAIT, DONE, HOLD.
- SYNC: when rel=1, go to WAIT with idx=0, cnt=0.
- WAIT, when cnt == dly_i[idx]:
  - set rst_n_o[idx]=1 and cnt=0;
  - if idx == CH_NUM-1, go to DONE and set done_o=1; otherwise idx++.
- WAIT, otherwise: cnt++.
- DONE, when |sw_rst_req_i: let k = lowest set index.
  - Clear rst_n_o[CH_NUM-1:k].
  - Set done_o=0, idx=k, cnt=0, pulse sw_rst_ack_o.
  - Go to HOLD.
- HOLD, when any request j is high:
  - clear rst_n_o[CH_NUM-1:j] for the lowest such j;
  - idx = min(idx, j); cnt = 0; no new ack.
- HOLD, with no request and cnt == STRETCH-1: go to WAIT with cnt=0. The sequence restarts from idx.
- HOLD, otherwise: cnt++.
- Requests in SYNC or WAIT are ignored. Because requests are levels, a request still held is taken once DONE is reached.
- cnt width: CNT_W = max(DLY_W, $clog2(STRETCH)+1). It never wraps, since its compare bounds are below 2^CNT_W.
- Channels below idx keep their value throughout HOLD/WAIT.

## Timing
- All outputs come straight from flops, so they are glitch-free. Assertion is immediate (async); release is clocked.
- Let E1 be the first rising edge with rst_i low:
  - rel goes high after E_STAGE;
  - the FSM enters WAIT at E_(STAGE+1);
  - channel k is released at edge E_(STAGE+1+Σ_{j≤k}(dly_i[j]+1)).
- done_o rises on the same edge as the last channel's release.
- Software path, with the request sampled at edge A:
  - rst_n_o[CH-1:k] goes low and ack is high after A;
  - with no further requests, WAIT is entered at A+STRETCH;
  - channel k is released at A+STRETCH+dly_i[k]+1.
- A request held for n cycles pushes the WAIT entry to (last high edge)+STRETCH.

## Configuration
- RST_SEQ_SW_RST_EN defined: software path as above.
- Undefined:
  - HOLD is not generated and DONE is terminal;
  - sw_rst_req_i is ignored and sw_rst_ack_o is tied 0;
  - ports are kept identical, so integration is unchanged.

## Structure
- rst_seq_pkg holds the state enum rst_seq_state_e {SYNC, WAIT, DONE, HOLD} and the CNT_W computation function.
- Sub-module rst_seq_sync is the STAGE-deep async-clear release synchroniser. It is instantiated once and reused in other domains.
- The top level holds the FSM, idx/cnt, and the per-channel output flops, using the dffr-style async-clear registers.

## Test plan
- CH_NUM=4, STAGE=3, dly={0,1,2,3}; rst_i deasserted → channels 0..3 released at E5, E7, E10, E14; done_o at E14.
- rst_i pulsed at E8 during the above → all rst_n_o=0 and done_o=0 immediately; after release the sequence reruns from E1 timing.
- In DONE, STRETCH=16, sw_rst_req_i=4'b0100 for 1 cycle at A → rst_n_o=4'b0011 after A, one ack pulse; ch2 released at A+19, ch3 at A+23.
- sw_rst_req_i=4'b1010 simultaneously → rst_n_o=4'b0001; release restarts at ch1: ch1 at A+18, ch2 at A+21, ch3 at A+25.
- ch3 request held 40 cycles, then ch0 requested at cycle 10 of HOLD → all channels low, single ack, release from ch0 starts 16 cycles after last request high.
- Macro undefined: any sw_rst_req_i in DONE → rst_n_o stays 4'b1111, ack stays 0.
